controlador_somador_serial: RTL and testbench

CONTROLADOR_SOMADOR_SERIAL -- requirements
Module: controlador_somador_serial

---
 rtl/controlador_somador_serial_pkg.sv | 15 +
 rtl/somador_subtrator.sv | 23 ++
 rtl/controlador_somador_serial.sv | 108 ++++++++++
 tb/tb_controlador_somador_serial.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/controlador_somador_serial_pkg.sv
// Shared types and constants for the serial adder/subtractor controller.
package controlador_somador_serial_pkg;

    // Controller states: wait for a request, process one bit per cycle, flag the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } estado_t;

    // Mode select values for the M input.
    localparam logic MODO_SOMA = 1'b0;
    localparam logic MODO_SUB  = 1'b1;

endpackage

// File: rtl/somador_subtrator.sv
// 1-bit full adder / full subtractor cell.
// M=MODO_SOMA: S = A+B+Te, Ts = carry-out.  M=MODO_SUB: S = A-B-Te, Ts = borrow-out.
module somador_subtrator
    import controlador_somador_serial_pkg::*;
(
    input  logic M,
    input  logic A,
    input  logic B,
    input  logic Te,
    output logic S,
    output logic Ts
);

    logic a_eff;

    // Inverting A turns the carry equation into the borrow equation.
    always_comb begin
        a_eff = (M == MODO_SUB) ? ~A : A;
        S     = A ^ B ^ Te;
        Ts    = (a_eff & B) | (Te & (a_eff ^ B));
    end

endmodule

// File: rtl/controlador_somador_serial.sv
// Serial N-bit adder/subtractor: one bit per clock, LSB first, through a single 1-bit cell.
// Handshake: a request is accepted only when start=1 while the block is idle (busy=0);
// busy stays high from the cycle after acceptance until the done cycle inclusive, done pulses
// for exactly one cycle with S/Ts valid, and S/Ts then hold until the next accepted request.
// Anything presented on start/A/B/M while busy=1 is dropped, never queued.
module controlador_somador_serial
    import controlador_somador_serial_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         M,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Ts,
    output estado_t      dbg_estado_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] ULTIMO_BIT = CW'(N - 1);

    estado_t        estado_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           m_q;
    logic           te_q;
    logic [N-1:0]   s_q;
    logic           busy_q;
    logic           done_q;

    logic           s_bit;
    logic           ts_bit;

    // All bit-level arithmetic lives in the shared cell; it sees the current operand LSBs.
    somador_subtrator u_celula (
        .M  (m_q),
        .A  (a_q[0]),
        .B  (b_q[0]),
        .Te (te_q),
        .S  (s_bit),
        .Ts (ts_bit)
    );

    // Controller FSM plus every datapath register, with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= MODO_SOMA;
            te_q     <= 1'b0;
            s_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        m_q      <= M;
                        cnt_q    <= '0;
                        te_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        estado_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Result bits enter from the MSB side so bit 0 ends up at S[0].
                    s_q   <= {s_bit, s_q[N-1:1]};
                    te_q  <= ts_bit;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ULTIMO_BIT) begin
                        done_q   <= 1'b1;
                        estado_q <= DONE;
                    end
                end
                DONE: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    estado_q <= IDLE;
                end
                default: begin
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    estado_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign S            = s_q;
    assign Ts           = te_q;
    assign dbg_estado_o = estado_q;

endmodule

// File: tb/tb_controlador_somador_serial.sv
// Directed bench for the serial adder/subtractor controller (N=8).
module tb_controlador_somador_serial;
    import controlador_somador_serial_pkg::*;

    localparam int N = 8;
    localparam int LAT = N + 2;

    // ---------------- clock / reset / DUT ----------------
    logic         clk;
    logic         rst;
    logic         start;
    logic         M;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         Ts;
    estado_t      dbg_estado;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    controlador_somador_serial #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .M            (M),
        .A            (A),
        .B            (B),
        .busy         (busy),
        .done         (done),
        .S            (S),
        .Ts           (Ts),
        .dbg_estado_o (dbg_estado)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         m;
        logic [N-1:0] s;
        logic         ts;
    } vec_t;

    vec_t vecs[11];

    // ---------------- driver tasks ----------------
    // Pulses start for one cycle (cycle 1) and observes cycles 2..LAT+4 at the falling edge.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                          output int done_cyc, output int busy_cnt, output int done_cnt);
        @(negedge clk);
        A = a; B = b; M = m; start = 1'b1;
        done_cyc = -1; busy_cnt = 0; done_cnt = 0;
        for (int c = 2; c <= LAT + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
    endtask

    int dc, bc, dn;
    int first_done, second_done;

    initial begin
        vecs[0]  = '{8'h35, 8'h4A, MODO_SOMA, 8'h7F, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, MODO_SOMA, 8'h00, 1'b1};
        vecs[2]  = '{8'h10, 8'h01, MODO_SUB,  8'h0F, 1'b0};
        vecs[3]  = '{8'h01, 8'h02, MODO_SUB,  8'hFF, 1'b1};
        vecs[4]  = '{8'h00, 8'h00, MODO_SUB,  8'h00, 1'b0};
        vecs[5]  = '{8'h80, 8'h80, MODO_SOMA, 8'h00, 1'b1};
        vecs[6]  = '{8'hAA, 8'h55, MODO_SOMA, 8'hFF, 1'b0};
        vecs[7]  = '{8'h00, 8'hFF, MODO_SUB,  8'h01, 1'b1};
        vecs[8]  = '{8'hFF, 8'hFF, MODO_SUB,  8'h00, 1'b0};
        vecs[9]  = '{8'hC3, 8'h3C, MODO_SOMA, 8'hFF, 1'b0};
        vecs[10] = '{8'h7F, 8'h80, MODO_SUB,  8'hFF, 1'b1};

        rst = 1'b1; start = 1'b0; M = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s",    32'(S),    32'd0);
        chk("rst_ts",   32'(Ts),   32'd0);
        chk("rst_state", 32'(dbg_estado), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Table-driven functional vectors with latency and pulse checks.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, dc, bc, dn);
            chk($sformatf("v%0d_s", i),        32'(S),  32'(vecs[i].s));
            chk($sformatf("v%0d_ts", i),       32'(Ts), 32'(vecs[i].ts));
            chk($sformatf("v%0d_done_cyc", i), dc, LAT);
            chk($sformatf("v%0d_busy_cnt", i), bc, N + 1);
            chk($sformatf("v%0d_done_cnt", i), dn, 1);
        end

        // Changes while busy and start during DONE are ignored.
        @(negedge clk);
        A = 8'h35; B = 8'h4A; M = MODO_SOMA; start = 1'b1;
        dn = 0; bc = 0;
        for (int c = 2; c <= 2 * LAT; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
            if (done) dn++;
            if (c == 3) chk("ign_state_shift", 32'(dbg_estado), 32'(SHIFT));
            if (c == 5) begin A = 8'hFF; B = 8'hFF; M = MODO_SUB; start = 1'b1; end
            if (c == LAT) begin
                chk("ign_state_done", 32'(dbg_estado), 32'(DONE));
                start = 1'b1;
            end
        end
        chk("ign_s",        32'(S),  32'h7F);
        chk("ign_ts",       32'(Ts), 32'd0);
        chk("ign_done_cnt", dn, 1);
        chk("ign_busy_cnt", bc, N + 1);
        chk("ign_idle",     32'(dbg_estado), 32'(IDLE));

        // Reset in the 5th SHIFT cycle aborts the operation without a done pulse.
        @(negedge clk);
        A = 8'hFF; B = 8'h01; M = MODO_SOMA; start = 1'b1;
        dn = 0;
        for (int c = 2; c <= 2 * LAT; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dn++;
            if (c == 6) rst = 1'b1;
            if (c == 7) begin
                chk("mid_rst_busy",  32'(busy), 32'd0);
                chk("mid_rst_s",     32'(S),    32'd0);
                chk("mid_rst_ts",    32'(Ts),   32'd0);
                chk("mid_rst_state", 32'(dbg_estado), 32'(IDLE));
                rst = 1'b0;
            end
        end
        chk("mid_rst_no_done", dn, 0);
        run_op(8'h10, 8'h01, MODO_SUB, dc, bc, dn);
        chk("post_rst_s",        32'(S),  32'h0F);
        chk("post_rst_ts",       32'(Ts), 32'd0);
        chk("post_rst_done_cyc", dc, LAT);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; A = 8'h01; B = 8'h01; M = MODO_SOMA;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy",  32'(busy), 32'd0);
        chk("rst_prio_state", 32'(dbg_estado), 32'(IDLE));

        // Start held high: back-to-back operations every LAT cycles.
        @(negedge clk);
        A = 8'h01; B = 8'h01; M = MODO_SOMA; start = 1'b1;
        dn = 0; first_done = -1; second_done = -1;
        for (int c = 2; c <= 3 * LAT + 1; c++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 3 * LAT + 1) start = 1'b0;
        end
        chk("b2b_done_cnt", dn, 3);
        chk("b2b_first",    first_done, LAT);
        chk("b2b_period",   second_done - first_done, LAT);
        chk("b2b_s",        32'(S), 32'h02);
        repeat (LAT + 2) @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
